uart_fifo_tx: RTL and testbench



---
 rtl/uart_fifo_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_fifo_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
//   Byte-serial UART transmitter that drains the read port of the UART FIFO.
//   It pops one byte per frame, waits out the FIFO read latency, and then
//   shifts the byte out LSB-first with optional parity and 1 or 2 stop bits.
//   Everything runs on the FIFO read clock. All outputs are registered.
//
// Ports
//   rd_clk         FIFO read clock
//   rd_rst         asynchronous, active-high reset
//   fifo_rd_en     pop strobe, one cycle per byte
//   fifo_rd_data   FIFO read data, valid c_RD_LATENCY cycles after the pop
//   fifo_rd_empty  FIFO empty flag
//   tx_enable      allows a new frame to start (sampled in IDLE only)
//   uart_tx        serial line, idle high
//   tx_busy        high from the pop cycle until the end of the stop bits
//   tx_byte_cnt    count of completed frames, wraps at 16 bits
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high; pop a byte when enabled and the FIFO is not empty
// FETCH  | pop cycle plus c_RD_LATENCY wait cycles; latch byte and parity
// START  | start bit (line low)
// DATA   | 8 data bits, LSB first
// PARITY | parity bit (skipped when c_PARITY is "NONE")
// STOP   | 1 or 2 stop bits (line high); frame counted on the last cycle

module uart_fifo_tx #(
    parameter int    c_CLKS_PER_BIT = 434,
    parameter int    c_RD_LATENCY   = 1,
    parameter string c_PARITY       = "NONE",
    parameter int    c_STOP_BITS    = 1
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_rd_empty,
    input  logic        tx_enable,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic [15:0] tx_byte_cnt
);

    localparam logic [15:0] c_BAUD_MAX  = 16'(c_CLKS_PER_BIT - 1);
    localparam logic [1:0]  c_LAT       = 2'(c_RD_LATENCY);
    localparam logic        c_STOP_LAST = 1'(c_STOP_BITS - 1);
    localparam logic        c_HAS_PAR   = (c_PARITY != "NONE");
    localparam logic        c_ODD       = (c_PARITY == "ODD");

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [1:0]  lat_cnt, lat_n;
    logic        stop_idx, stop_n;
    logic [7:0]  shreg, shreg_n;
    logic        par_bit, par_n;
    logic        tx_n;
    logic        rd_en_n;
    logic        busy_n;
    logic [15:0] cnt_n;
    logic        bit_end;
    logic [2:0]  idx_inc;

    assign bit_end = (baud_cnt == c_BAUD_MAX);
    assign idx_inc = bit_idx + 3'd1;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            lat_cnt     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            uart_tx     <= 1'b1;
            fifo_rd_en  <= 1'b0;
            tx_busy     <= 1'b0;
            tx_byte_cnt <= '0;
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_n;
            bit_idx     <= bit_idx_n;
            lat_cnt     <= lat_n;
            stop_idx    <= stop_n;
            shreg       <= shreg_n;
            par_bit     <= par_n;
            uart_tx     <= tx_n;
            fifo_rd_en  <= rd_en_n;
            tx_busy     <= busy_n;
            tx_byte_cnt <= cnt_n;
        end
    end

    // uart_tx is registered, so tx_n is the line value for the cycle after
    // this one: on a bit boundary it already carries the next bit.
    always_comb begin
        state_n   = state;
        baud_n    = bit_end ? 16'd0 : baud_cnt + 16'd1;
        bit_idx_n = bit_idx;
        lat_n     = lat_cnt;
        stop_n    = stop_idx;
        shreg_n   = shreg;
        par_n     = par_bit;
        tx_n      = 1'b1;
        rd_en_n   = 1'b0;
        busy_n    = tx_busy;
        cnt_n     = tx_byte_cnt;

        case (state)
            IDLE: begin
                baud_n = '0;
                if (tx_enable && !fifo_rd_empty) begin
                    rd_en_n = 1'b1;
                    busy_n  = 1'b1;
                    lat_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                // lat_cnt is 0 in the pop cycle; data is valid at c_LAT.
                baud_n = '0;
                if (lat_cnt == c_LAT) begin
                    shreg_n = fifo_rd_data;
                    par_n   = (^fifo_rd_data) ^ c_ODD;
                    tx_n    = 1'b0;
                    state_n = START;
                end else begin
                    lat_n = lat_cnt + 2'd1;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                end
            end
            DATA: begin
                tx_n = shreg[bit_idx];
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        if (c_HAS_PAR) begin
                            state_n = PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            stop_n  = 1'b0;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = idx_inc;
                        tx_n      = shreg[idx_inc];
                    end
                end
            end
            PARITY: begin
                tx_n = par_bit;
                if (bit_end) begin
                    state_n = STOP;
                    stop_n  = 1'b0;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == c_STOP_LAST) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        cnt_n   = tx_byte_cnt + 16'd1;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Testbench for uart_fifo_tx. Three instances share clock and reset:
//   dut_a: 4 clks/bit, latency 1, no parity, 1 stop bit
//   dut_e: 4 clks/bit, latency 2, even parity, 2 stop bits
//   dut_o: 4 clks/bit, latency 1, odd parity, 2 stop bits
// Each has a small FIFO model that drives random junk on fifo_rd_data
// except in the cycle the popped byte is valid.

module tb_uart_fifo_tx;

    localparam int c_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rd_en_a, empty_a, en_a, tx_a, busy_a;
    logic        rd_en_e, empty_e, en_e, tx_e, busy_e;
    logic        rd_en_o, empty_o, en_o, tx_o, busy_o;
    logic [7:0]  data_a = 8'h00, data_e = 8'h00, data_o = 8'h00;
    logic [15:0] cnt_a, cnt_e, cnt_o;

    logic [7:0] q_a[$];
    logic [7:0] q_e[$];
    logic [7:0] q_o[$];

    assign empty_a = (q_a.size() == 0);
    assign empty_e = (q_e.size() == 0);
    assign empty_o = (q_o.size() == 0);

    uart_fifo_tx #(.c_CLKS_PER_BIT(c_N), .c_RD_LATENCY(1), .c_PARITY("NONE"), .c_STOP_BITS(1)) dut_a (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_a), .fifo_rd_data(data_a),
        .fifo_rd_empty(empty_a), .tx_enable(en_a), .uart_tx(tx_a), .tx_busy(busy_a),
        .tx_byte_cnt(cnt_a));

    uart_fifo_tx #(.c_CLKS_PER_BIT(c_N), .c_RD_LATENCY(2), .c_PARITY("EVEN"), .c_STOP_BITS(2)) dut_e (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_e), .fifo_rd_data(data_e),
        .fifo_rd_empty(empty_e), .tx_enable(en_e), .uart_tx(tx_e), .tx_busy(busy_e),
        .tx_byte_cnt(cnt_e));

    uart_fifo_tx #(.c_CLKS_PER_BIT(c_N), .c_RD_LATENCY(1), .c_PARITY("ODD"), .c_STOP_BITS(2)) dut_o (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_o), .fifo_rd_data(data_o),
        .fifo_rd_empty(empty_o), .tx_enable(en_o), .uart_tx(tx_o), .tx_busy(busy_o),
        .tx_byte_cnt(cnt_o));

    // FIFO models
    logic [7:0] s_e1 = 8'h00;
    logic       v_e1 = 1'b0;

    always @(posedge clk) begin
        if (rd_en_a && q_a.size() > 0) data_a <= q_a.pop_front();
        else data_a <= 8'($urandom);
    end

    always @(posedge clk) begin
        v_e1 <= 1'b0;
        if (rd_en_e && q_e.size() > 0) begin
            s_e1 <= q_e.pop_front();
            v_e1 <= 1'b1;
        end
        data_e <= v_e1 ? s_e1 : 8'($urandom);
    end

    always @(posedge clk) begin
        if (rd_en_o && q_o.size() > 0) data_o <= q_o.pop_front();
        else data_o <= 8'($urandom);
    end

    // pop counting and pop-while-empty detection
    int pops_a = 0, pops_e = 0, pops_o = 0;
    int bad_pops = 0;

    always @(negedge clk) begin
        if (rd_en_a) begin pops_a++; if (empty_a) bad_pops++; end
        if (rd_en_e) begin pops_e++; if (empty_e) bad_pops++; end
        if (rd_en_o) begin pops_o++; if (empty_o) bad_pops++; end
    end

    // view of the instance under test
    int          sel = 0;
    logic        cur_tx, cur_busy;
    logic [15:0] cur_cnt;

    always_comb begin
        case (sel)
            1:       begin cur_tx = tx_e; cur_busy = busy_e; cur_cnt = cnt_e; end
            2:       begin cur_tx = tx_o; cur_busy = busy_o; cur_cnt = cnt_o; end
            default: begin cur_tx = tx_a; cur_busy = busy_a; cur_cnt = cnt_a; end
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int pops_of(input int s);
        case (s)
            1:       return pops_e;
            2:       return pops_o;
            default: return pops_a;
        endcase
    endfunction

    task automatic push(input int s, input logic [7:0] b);
        case (s)
            1:       q_e.push_back(b);
            2:       q_o.push_back(b);
            default: q_a.push_back(b);
        endcase
    endtask

    task automatic set_en(input int s);
        en_a = (s == 0);
        en_e = (s == 1);
        en_o = (s == 2);
    endtask

    // Records one busy window of the selected instance and checks its length,
    // the start-bit position, every bit of the frame and the frame counter.
    task automatic capture(input logic [7:0] b, input int pre, input int len, input int busy_exp,
                           input bit has_par, input bit par, input logic [15:0] cnt_exp,
                           output int waited);
        logic       rec [256];
        logic [3:0] smp;
        logic       e;
        int         n, blen, fz, idx;
        n = 0;
        while (!cur_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        blen = 0;
        while (cur_busy && blen < 256) begin
            rec[blen] = cur_tx;
            blen++;
            @(negedge clk);
        end
        check($sformatf("busy_len_%02h", b), blen, busy_exp);
        fz = -1;
        for (int k = 0; k < blen; k++)
            if (fz < 0 && rec[k] == 1'b0) fz = k;
        check($sformatf("start_pos_%02h", b), fz, pre);
        for (int j = 0; j < len / c_N; j++) begin
            if (j == 0)                   e = 1'b0;
            else if (j <= 8)              e = b[j-1];
            else if (has_par && j == 9)   e = par;
            else                          e = 1'b1;
            for (int s = 0; s < c_N; s++) begin
                idx = pre + c_N * j + s;
                smp[s] = (idx < blen) ? rec[idx] : ~e;
            end
            check($sformatf("frame_%02h_bit%0d", b, j), smp, {4{e}});
        end
        check($sformatf("byte_cnt_%02h", b), cur_cnt, cnt_exp);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] b;
        int         pre;
        int         len;
        int         busy;
        bit         has_par;
        bit         par;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [6];
        logic [7:0] b2b [3];
        int         ecnt [3];
        int         p0, w, n;
        logic       line_ok;

        //        sel  byte    pre len busy par? par
        vecs[0] = '{0, 8'hA5, 2, 40, 42, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h07, 3, 48, 51, 1'b1, 1'b1};
        vecs[2] = '{2, 8'h07, 2, 48, 50, 1'b1, 1'b0};
        vecs[3] = '{1, 8'h3C, 3, 48, 51, 1'b1, 1'b0};
        vecs[4] = '{2, 8'h00, 2, 48, 50, 1'b1, 1'b1};
        vecs[5] = '{0, 8'hC3, 2, 40, 42, 1'b0, 1'b0};
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
        ecnt[0] = 0; ecnt[1] = 0; ecnt[2] = 0;
        set_en(3);

        repeat (3) @(negedge clk);
        check("rst_tx_a",    tx_a,    1);
        check("rst_busy_a",  busy_a,  0);
        check("rst_rden_a",  rd_en_a, 0);
        check("rst_cnt_a",   cnt_a,   0);
        check("rst_tx_e",    tx_e,    1);
        check("rst_cnt_o",   cnt_o,   0);
        rst = 1'b0;
        set_en(0);
        repeat (3) @(negedge clk);
        check("empty_idle_tx",   tx_a,    1);
        check("empty_idle_busy", busy_a,  0);
        check("empty_idle_rden", rd_en_a, 0);

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            set_en(sel);
            p0 = pops_of(sel);
            push(sel, vecs[i].b);
            ecnt[sel]++;
            capture(vecs[i].b, vecs[i].pre, vecs[i].len, vecs[i].busy,
                    vecs[i].has_par, vecs[i].par, 16'(ecnt[sel]), w);
            check($sformatf("pops_vec%0d", i), pops_of(sel) - p0, 1);
        end

        // back-to-back frames: one idle cycle, then pop, latency, start bit
        sel = 0;
        set_en(0);
        p0 = pops_of(0);
        for (int i = 0; i < 3; i++) push(0, b2b[i]);
        for (int i = 0; i < 3; i++) begin
            ecnt[0]++;
            capture(b2b[i], 2, 40, 42, 1'b0, 1'b0, 16'(ecnt[0]), w);
            check($sformatf("b2b_idle_gap%0d", i), w, 1);
        end
        check("b2b_pops", pops_of(0) - p0, 3);

        // flow control: drop enable during data bit 3
        p0 = pops_of(0);
        push(0, 8'h11);
        push(0, 8'h22);
        n = 0;
        while (!busy_a && n < 20) begin @(negedge clk); n++; end
        repeat (19) @(negedge clk);
        en_a = 1'b0;
        n = 0;
        while (busy_a && n < 200) begin @(negedge clk); n++; end
        check("flow_frame_done", busy_a, 0);
        ecnt[0]++;
        check("flow_cnt", cnt_a, 16'(ecnt[0]));
        line_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) line_ok = 1'b0;
        end
        check("flow_hold_pops", pops_of(0) - p0, 1);
        check("flow_hold_line", line_ok, 1);
        en_a = 1'b1;
        @(negedge clk);
        check("flow_repop", rd_en_a, 1);
        ecnt[0]++;
        capture(8'h22, 2, 40, 42, 1'b0, 1'b0, 16'(ecnt[0]), w);
        check("flow_pops", pops_of(0) - p0, 2);

        // reset during data bit 5 of 0x96 (line low there)
        p0 = pops_of(0);
        push(0, 8'h96);
        push(0, 8'h69);
        n = 0;
        while (!busy_a && n < 20) begin @(negedge clk); n++; end
        repeat (26) @(negedge clk);
        check("rst_mid_line_before", tx_a, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_tx",   tx_a,    1);
        check("rst_mid_busy", busy_a,  0);
        check("rst_mid_cnt",  cnt_a,   0);
        check("rst_mid_rden", rd_en_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        capture(8'h69, 2, 40, 42, 1'b0, 1'b0, 16'd1, w);
        check("rst_pops", pops_of(0) - p0, 2);

        check("no_pop_when_empty", bad_pops, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
